// File: rtl/gc_tx_frame.sv
// gc_tx_frame: buffers host bytes and serializes them MSB-first, byte 0 first, into the N64/GC pulse stage, then a stop bit.
// Optional watchdog abort is compiled in when GC_TX_TIMEOUT_EN is defined.
module gc_tx_frame #(
  parameter int unsigned MAX_BYTES      = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              pulse_busy,
  output logic              pulse_trigger,
  output logic [1:0]        pulse_digit,
  output logic              busy,
  output logic              done,
  output logic              wr_full,
  output logic [ADDR_W:0]   byte_count,
  output logic              err
);

  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned IDX_W      = (ADDR_W == 0) ? 1 : ADDR_W;
  localparam logic [1:0]  DIGIT_STOP = 2'b11;

  if (MAX_BYTES != (1 << ADDR_W) || MAX_BYTES > 64 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("gc_tx_frame: MAX_BYTES must equal 2**ADDR_W (at most 64) and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TRIG,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         buf_q [MAX_BYTES];
  logic [7:0]         buf_d [MAX_BYTES];
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               is_stop_q, is_stop_d;
  logic               pulse_trigger_q, pulse_trigger_d;
  logic [1:0]         pulse_digit_q, pulse_digit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_full_q, wr_full_d;
  logic [CNT_W-1:0]   byte_count_q, byte_count_d;
  logic               wr_accept_c;
  logic               last_bit_c;
  logic               timeout_c;

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_SETUP;
      S_SETUP:     state_d = S_TRIG;
      S_TRIG:      state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (timeout_c)       state_d = S_IDLE;
        else if (pulse_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (timeout_c)        state_d = S_IDLE;
        else if (!pulse_busy) state_d = is_stop_q ? S_FINISH : S_SETUP;
      end
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign last_bit_c = (bit_idx_q == 3'd0) &&
                      (CNT_W'(byte_idx_q) == byte_count_q - CNT_W'(1));

  // Buffer writes, bit pointer and registered output values
  always_comb begin
    buf_d           = buf_q;
    byte_idx_d      = byte_idx_q;
    bit_idx_d       = bit_idx_q;
    is_stop_d       = is_stop_q;
    pulse_digit_d   = pulse_digit_q;
    busy_d          = busy_q;
    byte_count_d    = byte_count_q;
    pulse_trigger_d = (state_d == S_TRIG);
    done_d          = 1'b0;
    wr_accept_c     = (state_q == S_IDLE) && wr_en && (byte_count_q != CNT_W'(MAX_BYTES));

    if (wr_accept_c) begin
      buf_d[byte_count_q[IDX_W-1:0]] = wr_data;
      byte_count_d                   = byte_count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d        = 1'b1;
          byte_idx_d    = '0;
          bit_idx_d     = 3'd7;
          is_stop_d     = (byte_count_d == '0);
          pulse_digit_d = is_stop_d ? DIGIT_STOP : {1'b0, buf_d[0][7]};
        end
      end
      S_WAIT_ACK, S_WAIT_DONE: begin
        if (timeout_c) begin
          pulse_digit_d = DIGIT_STOP;
          byte_count_d  = '0;
          busy_d        = 1'b0;
        end else if (state_q == S_WAIT_DONE && !pulse_busy && !is_stop_q) begin
          if (last_bit_c) begin
            pulse_digit_d = DIGIT_STOP;
            is_stop_d     = 1'b1;
          end else if (bit_idx_q == 3'd0) begin
            byte_idx_d    = byte_idx_q + IDX_W'(1);
            bit_idx_d     = 3'd7;
            pulse_digit_d = {1'b0, buf_q[byte_idx_d][7]};
          end else begin
            bit_idx_d     = bit_idx_q - 3'd1;
            pulse_digit_d = {1'b0, buf_q[byte_idx_q][bit_idx_d]};
          end
        end
      end
      S_FINISH: begin
        done_d        = 1'b1;
        busy_d        = 1'b0;
        byte_count_d  = '0;
        pulse_digit_d = DIGIT_STOP;
      end
      default: ;
    endcase

    wr_full_d = (byte_count_d == CNT_W'(MAX_BYTES));
  end

  // Datapath and output registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      byte_idx_q      <= '0;
      bit_idx_q       <= 3'd0;
      is_stop_q       <= 1'b0;
      pulse_trigger_q <= 1'b0;
      pulse_digit_q   <= DIGIT_STOP;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      wr_full_q       <= 1'b0;
      byte_count_q    <= '0;
    end else begin
      byte_idx_q      <= byte_idx_d;
      bit_idx_q       <= bit_idx_d;
      is_stop_q       <= is_stop_d;
      pulse_trigger_q <= pulse_trigger_d;
      pulse_digit_q   <= pulse_digit_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      wr_full_q       <= wr_full_d;
      byte_count_q    <= byte_count_d;
    end
  end

  // Frame storage; validity is tracked by byte_count, so no reset needed
  always_ff @(posedge sys_clk) begin
    buf_q <= buf_d;
  end

`ifdef GC_TX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;

  assign timeout_c = (state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts only while waiting on the pulse stage, restarting on every state change
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) && state_d == state_q)
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    err_d = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    else if (timeout_c)             err_d = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

  assign pulse_trigger = pulse_trigger_q;
  assign pulse_digit   = pulse_digit_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_full       = wr_full_q;
  assign byte_count    = byte_count_q;

endmodule

// File: doc/gc_tx_frame.md
Name: gc_tx_frame

Overview:
- Frame serializer directly upstream of the N64/GC bit-pulse stage.
- Buffers up to MAX_BYTES command bytes written by the host-side logic, then drives the pulse stage one bit at a time, MSB first, byte 0 first.
- Issues digit plus trigger for each bit, tracks the pulse stage's busy flag, and appends the stop bit.
- Reports frame completion to the host with a one-cycle done strobe.

Parameters:
- MAX_BYTES, 8, buffer depth in bytes; power of two, 1..64.
- ADDR_W, 3, log2(MAX_BYTES).
- TIMEOUT_CYCLES, 1024, watchdog limit in sys_clk cycles; used only with GC_TX_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock, 48 MHz.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write strobe; pushes wr_data into the buffer.
- wr_data  in  8  byte to append to the frame.
- start  in  1  one-cycle request to transmit the buffered frame.
- pulse_busy  in  1  pulse stage "transmitting" flag.
- pulse_trigger  out  1  rising edge starts one bit in the pulse stage.
- pulse_digit  out  2  symbol to the pulse stage: 00 = zero, 01 = one, 11 = stop.
- busy  out  1  frame in progress.
- done  out  1  one-cycle strobe when the stop bit completes.
- wr_full  out  1  buffer holds MAX_BYTES bytes.
- byte_count  out  ADDR_W+1  number of bytes currently buffered.
- err  out  1  watchdog abort flag; constant 0 without GC_TX_TIMEOUT_EN.

Behaviour:
- Reset values: pulse_trigger=0, pulse_digit=11, busy=0, done=0, wr_full=0, byte_count=0, err=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts immediately and empties the buffer, with no stop bit sent.
- Writes:
  - Accepted only in IDLE with byte_count<MAX_BYTES. Data goes to buffer[byte_count], and byte_count increments.
  - Writes while busy or full are dropped silently; byte_count is unchanged.
  - wr_full = (byte_count==MAX_BYTES), registered.
- wr_en and start in the same IDLE cycle: the write is accepted and included as the last byte of the frame.
- start while busy: ignored.
- start with byte_count==0: a stop-only frame is sent.
- States: IDLE, SETUP, TRIG, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE -> SETUP on start:
  - busy=1 at the same edge.
  - Bit counter, byte index and is_stop are loaded.
  - pulse_digit = {0, first data bit}, or 11 if the frame is stop-only.
- SETUP -> TRIG after exactly one cycle. pulse_digit has been stable for at least 1 cycle before the trigger rises.
- TRIG: pulse_trigger=1 for exactly one cycle, then -> WAIT_ACK with pulse_trigger=0.
- WAIT_ACK -> WAIT_DONE when pulse_busy=1 is sampled.
- WAIT_DONE, on pulse_busy=0:
  - If more data bits remain: advance the bit pointer (bit 7 down to 0, then the next byte), set the next digit, -> SETUP.
  - If the last data bit is done: pulse_digit=11, is_stop=1, -> SETUP.
  - If the stop bit is done: -> FINISH.
- FINISH: done=1 for one cycle; busy=0, byte_count=0, pulse_digit=11 at the same edge; -> IDLE.
- pulse_digit is held constant from SETUP until leaving WAIT_DONE.
- Bit timing is owned by the pulse stage. This block adds 3 sys_clk cycles of gap per bit (SETUP, TRIG, sample).
- Frame duration = (8*N+1) bit slots plus those gaps.
- pulse_busy asserted before WAIT_ACK is sampled: treated as the acknowledge on the first WAIT_ACK cycle.
- pulse_busy high while in IDLE: ignored.

Optional Feature:
- Macro GC_TX_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT_ACK and WAIT_DONE and clears on each state change.
  - If it reaches TIMEOUT_CYCLES, the frame aborts: pulse_digit=11, buffer emptied, busy=0, err=1, no done strobe, -> IDLE.
  - err stays set until the next accepted start or rst.
- When not defined: no counter is built, err is tied 0, and the block waits indefinitely.

Test Plan:
- Write 0x01, start, model pulse_busy (high 3 cycles after each trigger, low 192 cycles later) -> digits 00×7, 01, then 11; 9 triggers total; done one cycle after the stop bit's busy falls; byte_count returns to 0.
- Write 0x40,0x03,0x00 then start -> digit sequence 0100 0000 0000 0011 0000 0000 then 11; 25 triggers; busy high throughout.
- start with empty buffer -> exactly one trigger with digit 11, then done.
- Write 9 bytes with MAX_BYTES=8 -> wr_full=1 after the 8th write, byte_count=8, 9th byte never transmitted; wr_en during the frame has no effect.
- Assert rst during the 5th bit's WAIT_DONE -> all outputs reset values immediately, no further triggers; new write+start after release sends a normal frame.
- With GC_TX_TIMEOUT_EN, TIMEOUT_CYCLES=1024, hold pulse_busy=0 -> err=1 and busy=0 at 1024 cycles into WAIT_ACK, no done; next start clears err.
